// File: rtl/glb_pkg.sv
// ============================================================================
// glb_pkg : shared bank-select encoding and default widths for glb_cluster
// Revision: 1.0
// ============================================================================
`default_nettype none

package glb_pkg;

  localparam int GLB_DATA_BITWIDTH = 16;
  localparam int GLB_ADDR_BITWIDTH = 10;

  typedef enum logic [1:0] {
    GLB_IACT = 2'd0,
    GLB_WGHT = 2'd1,
    GLB_PSUM = 2'd2,
    GLB_NONE = 2'd3
  } glb_sel_e;

endpackage

`default_nettype wire

// File: rtl/glb_bank.sv
// ============================================================================
// glb_bank : synchronous RAM with registered read data (held between reads)
// Revision: 1.0
// ============================================================================
`default_nettype none

module glb_bank
  import glb_pkg::*;
#(
  parameter int DATA_W = GLB_DATA_BITWIDTH,
  parameter int ADDR_W = GLB_ADDR_BITWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  localparam int c_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [0:c_DEPTH-1];
  logic [DATA_W-1:0] rd_data_q;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/glb_cluster.sv
// ============================================================================
// glb_cluster : iact/weight/psum global buffer with router-priority host port
// Optional feature: GLB_PSUM_ACCUM_EN (psum read-modify-write accumulate)
// Revision: 1.0
// ============================================================================
`default_nettype none

module glb_cluster
  import glb_pkg::*;
#(
  parameter int DATA_BITWIDTH     = GLB_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH_GLB = GLB_ADDR_BITWIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         read_req_glb_iact,
  input  logic [ADDR_BITWIDTH_GLB-1:0] r_addr_glb_iact,
  output logic [DATA_BITWIDTH-1:0]     r_data_glb_iact,
  input  logic                         read_req_glb_wght,
  input  logic [ADDR_BITWIDTH_GLB-1:0] r_addr_glb_wght,
  output logic [DATA_BITWIDTH-1:0]     r_data_glb_wght,
  input  logic                         write_en_glb_psum,
  input  logic [ADDR_BITWIDTH_GLB-1:0] w_addr_glb_psum,
  input  logic [DATA_BITWIDTH-1:0]     w_data_glb_psum,
  input  logic [1:0]                   host_sel,
  input  logic                         host_we,
  input  logic                         host_re,
  input  logic [ADDR_BITWIDTH_GLB-1:0] host_addr,
  input  logic [DATA_BITWIDTH-1:0]     host_wdata,
  output logic                         host_ready,
  output logic [DATA_BITWIDTH-1:0]     host_rdata,
  output logic                         host_rvalid,
  output logic [ADDR_BITWIDTH_GLB:0]   psum_wr_count,
  input  logic                         host_clr_count
);

  localparam int DW = DATA_BITWIDTH;
  localparam int AW = ADDR_BITWIDTH_GLB;
  localparam logic [AW:0] c_CNT_MAX = '1;

  glb_sel_e sel;
  logic     psum_busy;
  logic     busy_sel;
  logic     host_wr_acc;
  logic     host_rd_acc;

  logic [DW-1:0] iact_rd, wght_rd, psum_rd;
  logic          psum_rd_en, psum_wr_en;
  logic [AW-1:0] psum_rd_addr, psum_wr_addr;
  logic [DW-1:0] psum_wr_data;

  assign sel = glb_sel_e'(host_sel);

  always_comb begin
    busy_sel = 1'b1;
    case (sel)
      GLB_IACT: busy_sel = read_req_glb_iact;
      GLB_WGHT: busy_sel = read_req_glb_wght;
      GLB_PSUM: busy_sel = psum_busy;
      default:  busy_sel = 1'b1;
    endcase
  end

  assign host_ready  = !busy_sel;
  // A request with both strobes set is illegal; the write takes precedence.
  assign host_wr_acc = host_ready && host_we;
  assign host_rd_acc = host_ready && host_re && !host_we;

  glb_bank #(.DATA_W(DW), .ADDR_W(AW)) u_iact (
    .clk       (clk),
    .rst       (reset),
    .rd_en_i   (read_req_glb_iact || (host_rd_acc && sel == GLB_IACT)),
    .rd_addr_i (read_req_glb_iact ? r_addr_glb_iact : host_addr),
    .rd_data_o (iact_rd),
    .wr_en_i   (host_wr_acc && sel == GLB_IACT),
    .wr_addr_i (host_addr),
    .wr_data_i (host_wdata)
  );

  glb_bank #(.DATA_W(DW), .ADDR_W(AW)) u_wght (
    .clk       (clk),
    .rst       (reset),
    .rd_en_i   (read_req_glb_wght || (host_rd_acc && sel == GLB_WGHT)),
    .rd_addr_i (read_req_glb_wght ? r_addr_glb_wght : host_addr),
    .rd_data_o (wght_rd),
    .wr_en_i   (host_wr_acc && sel == GLB_WGHT),
    .wr_addr_i (host_addr),
    .wr_data_i (host_wdata)
  );

  glb_bank #(.DATA_W(DW), .ADDR_W(AW)) u_psum (
    .clk       (clk),
    .rst       (reset),
    .rd_en_i   (psum_rd_en),
    .rd_addr_i (psum_rd_addr),
    .rd_data_o (psum_rd),
    .wr_en_i   (psum_wr_en),
    .wr_addr_i (psum_wr_addr),
    .wr_data_i (psum_wr_data)
  );

`ifdef GLB_PSUM_ACCUM_EN
  logic          s2_valid_q;
  logic [AW-1:0] s2_addr_q;
  logic [DW-1:0] s2_data_q;
  logic          fwd_q;
  logic [DW-1:0] fwd_data_q;
  logic [DW-1:0] acc_sum;

  // When the previous accumulate hit the same address, its sum was being
  // written while this one read the bank, so the stale read is bypassed.
  assign acc_sum = (fwd_q ? fwd_data_q : psum_rd) + s2_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      s2_valid_q <= write_en_glb_psum;
      s2_addr_q  <= w_addr_glb_psum;
      s2_data_q  <= w_data_glb_psum;
      fwd_q      <= s2_valid_q && (s2_addr_q == w_addr_glb_psum);
      fwd_data_q <= acc_sum;
    end
  end

  assign psum_busy    = write_en_glb_psum || s2_valid_q;
  assign psum_rd_en   = write_en_glb_psum || (host_rd_acc && sel == GLB_PSUM);
  assign psum_rd_addr = write_en_glb_psum ? w_addr_glb_psum : host_addr;
  assign psum_wr_en   = s2_valid_q || (host_wr_acc && sel == GLB_PSUM);
  assign psum_wr_addr = s2_valid_q ? s2_addr_q : host_addr;
  assign psum_wr_data = s2_valid_q ? acc_sum : host_wdata;
`else
  assign psum_busy    = write_en_glb_psum;
  assign psum_rd_en   = host_rd_acc && sel == GLB_PSUM;
  assign psum_rd_addr = host_addr;
  assign psum_wr_en   = write_en_glb_psum || (host_wr_acc && sel == GLB_PSUM);
  assign psum_wr_addr = write_en_glb_psum ? w_addr_glb_psum : host_addr;
  assign psum_wr_data = write_en_glb_psum ? w_data_glb_psum : host_wdata;
`endif

  // Bank read registers are shared with the host, so each consumer keeps
  // its own copy of the last value it was given.
  logic          iact_rtr_q, wght_rtr_q;
  logic [DW-1:0] iact_hold_q, wght_hold_q;
  logic          host_rd_q;
  glb_sel_e      host_sel_q;
  logic [DW-1:0] host_hold_q;
  logic [DW-1:0] host_bank_rd;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    host_bank_rd = iact_rd;
    case (host_sel_q)
      GLB_WGHT: host_bank_rd = wght_rd;
      GLB_PSUM: host_bank_rd = psum_rd;
      default:  host_bank_rd = iact_rd;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (host_clr_count) begin
      cnt_d = '0;
    end else if (write_en_glb_psum && cnt_q != c_CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iact_rtr_q  <= 1'b0;
      wght_rtr_q  <= 1'b0;
      iact_hold_q <= '0;
      wght_hold_q <= '0;
      host_rd_q   <= 1'b0;
      host_sel_q  <= GLB_IACT;
      host_hold_q <= '0;
      cnt_q       <= '0;
    end else begin
      iact_rtr_q <= read_req_glb_iact;
      wght_rtr_q <= read_req_glb_wght;
      if (iact_rtr_q) iact_hold_q <= iact_rd;
      if (wght_rtr_q) wght_hold_q <= wght_rd;
      host_rd_q <= host_rd_acc;
      if (host_rd_acc) host_sel_q <= sel;
      if (host_rd_q) host_hold_q <= host_bank_rd;
      cnt_q <= cnt_d;
    end
  end

  assign r_data_glb_iact = iact_rtr_q ? iact_rd : iact_hold_q;
  assign r_data_glb_wght = wght_rtr_q ? wght_rd : wght_hold_q;
  assign host_rdata      = host_rd_q ? host_bank_rd : host_hold_q;
  assign host_rvalid     = host_rd_q;
  assign psum_wr_count   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_glb_cluster.sv
// ============================================================================
// tb_glb_cluster : directed + random checks of glb_cluster against a bank model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_glb_cluster;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int CMAX  = (1 << (AW + 1)) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          read_req_glb_iact, read_req_glb_wght, write_en_glb_psum;
  logic [AW-1:0] r_addr_glb_iact, r_addr_glb_wght, w_addr_glb_psum, host_addr;
  logic [DW-1:0] w_data_glb_psum, host_wdata;
  logic [1:0]    host_sel;
  logic          host_we, host_re, host_clr_count;
  logic [DW-1:0] r_data_glb_iact, r_data_glb_wght, host_rdata;
  logic          host_ready, host_rvalid;
  logic [AW:0]   psum_wr_count;

  glb_cluster #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .read_req_glb_iact (read_req_glb_iact),
    .r_addr_glb_iact   (r_addr_glb_iact),
    .r_data_glb_iact   (r_data_glb_iact),
    .read_req_glb_wght (read_req_glb_wght),
    .r_addr_glb_wght   (r_addr_glb_wght),
    .r_data_glb_wght   (r_data_glb_wght),
    .write_en_glb_psum (write_en_glb_psum),
    .w_addr_glb_psum   (w_addr_glb_psum),
    .w_data_glb_psum   (w_data_glb_psum),
    .host_sel          (host_sel),
    .host_we           (host_we),
    .host_re           (host_re),
    .host_addr         (host_addr),
    .host_wdata        (host_wdata),
    .host_ready        (host_ready),
    .host_rdata        (host_rdata),
    .host_rvalid       (host_rvalid),
    .psum_wr_count     (psum_wr_count),
    .host_clr_count    (host_clr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: bank contents, counter, pending accumulate, expected outputs.
  logic [DW-1:0] m_mem [0:2][0:DEPTH-1];
  int            m_cnt = 0;
  bit            m_pv  = 1'b0;
  logic [AW-1:0] m_pa;
  logic [DW-1:0] m_pd;
  logic [DW-1:0] e_iact = '0, e_wght = '0, e_hd = '0;
  bit            e_hv  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    read_req_glb_iact = 0; read_req_glb_wght = 0; write_en_glb_psum = 0;
    r_addr_glb_iact = '0; r_addr_glb_wght = '0; w_addr_glb_psum = '0;
    w_data_glb_psum = '0; host_sel = 2'd3; host_we = 0; host_re = 0;
    host_addr = '0; host_wdata = '0; host_clr_count = 0;
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic step();
    bit busy, rdy, acc_w, acc_r;
    logic [DW-1:0] n_iact, n_wght, n_hd;
    #1;
    case (host_sel)
      2'd0: busy = read_req_glb_iact;
      2'd1: busy = read_req_glb_wght;
`ifdef GLB_PSUM_ACCUM_EN
      2'd2: busy = write_en_glb_psum || m_pv;
`else
      2'd2: busy = write_en_glb_psum;
`endif
      default: busy = 1'b1;
    endcase
    rdy = !busy;
    chk("host_ready", {31'd0, host_ready}, {31'd0, rdy});
    acc_w = rdy && host_we;
    acc_r = rdy && host_re && !host_we;
    n_iact = read_req_glb_iact ? m_mem[0][r_addr_glb_iact] : e_iact;
    n_wght = read_req_glb_wght ? m_mem[1][r_addr_glb_wght] : e_wght;
    n_hd = e_hd;
    if (acc_r) n_hd = m_mem[host_sel][host_addr];
    @(posedge clk);
`ifdef GLB_PSUM_ACCUM_EN
    if (m_pv) m_mem[2][m_pa] = m_mem[2][m_pa] + m_pd;
    m_pv = write_en_glb_psum; m_pa = w_addr_glb_psum; m_pd = w_data_glb_psum;
`else
    if (write_en_glb_psum) m_mem[2][w_addr_glb_psum] = w_data_glb_psum;
`endif
    if (acc_w) m_mem[host_sel][host_addr] = host_wdata;
    if (host_clr_count) m_cnt = 0;
    else if (write_en_glb_psum && m_cnt < CMAX) m_cnt++;
    e_iact = n_iact; e_wght = n_wght; e_hv = acc_r; e_hd = n_hd;
    #1;
    chk("r_data_iact", {16'd0, r_data_glb_iact}, {16'd0, e_iact});
    chk("r_data_wght", {16'd0, r_data_glb_wght}, {16'd0, e_wght});
    chk("host_rvalid", {31'd0, host_rvalid}, {31'd0, e_hv});
    if (e_hv) chk("host_rdata", {16'd0, host_rdata}, {16'd0, e_hd});
    chk("psum_wr_count", {21'd0, psum_wr_count}, m_cnt);
  endtask

  task automatic host_wr(input logic [1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle(); host_sel = s; host_we = 1; host_addr = a; host_wdata = d; step();
  endtask

  task automatic host_rd(input logic [1:0] s, input logic [AW-1:0] a);
    idle(); host_sel = s; host_re = 1; host_addr = a; step();
  endtask

  task automatic psum_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle(); write_en_glb_psum = 1; w_addr_glb_psum = a; w_data_glb_psum = d; step();
  endtask

  initial begin
    int rv;
    logic [DW-1:0] old9;
    idle();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_r_data_iact", {16'd0, r_data_glb_iact}, 0);
    chk("rst_r_data_wght", {16'd0, r_data_glb_wght}, 0);
    chk("rst_host_rdata", {16'd0, host_rdata}, 0);
    chk("rst_host_rvalid", {31'd0, host_rvalid}, 0);
    chk("rst_count", {21'd0, psum_wr_count}, 0);
    #1;
    chk("rst_ready_none", {31'd0, host_ready}, 0);
    host_sel = 2'd0; #1;
    chk("rst_ready_iact", {31'd0, host_ready}, 1);
    idle();
    @(posedge clk); #1;
    reset = 0;

    // Fill every bank so all later reads are defined.
    for (int b = 0; b < 3; b++)
      for (int a = 0; a < DEPTH; a++)
        host_wr(b[1:0], a[AW-1:0], DW'($urandom));

    // Preload and read
    host_wr(2'd0, 10'd5, 16'h00AA);
    host_wr(2'd1, 10'd7, 16'h0003);
    idle();
    read_req_glb_iact = 1; r_addr_glb_iact = 10'd5;
    read_req_glb_wght = 1; r_addr_glb_wght = 10'd7;
    step();
    chk("preload_iact", {16'd0, r_data_glb_iact}, 32'h00AA);
    chk("preload_wght", {16'd0, r_data_glb_wght}, 32'h0003);
    idle(); step();
    chk("hold_iact", {16'd0, r_data_glb_iact}, 32'h00AA);

    // Contention: host holds a read of iact[0] behind 4 router reads
    rv = 0;
    idle(); host_sel = 2'd0; host_re = 1; host_addr = '0;
    for (int i = 0; i < 4; i++) begin
      read_req_glb_iact = 1; r_addr_glb_iact = AW'($urandom);
      step();
      chk("cont_ready", {31'd0, host_ready}, 0);
      rv += int'(host_rvalid);
    end
    read_req_glb_iact = 0;
    step();
    chk("cont_rvalid_after", {31'd0, host_rvalid}, 1);
    chk("cont_rdata", {16'd0, host_rdata}, {16'd0, m_mem[0][0]});
    rv += int'(host_rvalid);
    host_re = 0;
    step(); rv += int'(host_rvalid);
    step(); rv += int'(host_rvalid);
    chk("cont_rvalid_once", rv, 1);

    // Psum drain
    idle(); host_clr_count = 1; step();
    for (int i = 0; i < 3; i++) host_wr(2'd2, i[AW-1:0], 16'h0000);
    psum_wr(10'd0, 16'h0010);
    psum_wr(10'd1, 16'h0020);
    psum_wr(10'd2, 16'h0030);
    idle(); step();
    chk("drain_count", {21'd0, psum_wr_count}, 3);
    host_rd(2'd2, 10'd0); chk("drain_0", {16'd0, host_rdata}, 32'h10);
    host_rd(2'd2, 10'd1); chk("drain_1", {16'd0, host_rdata}, 32'h20);
    host_rd(2'd2, 10'd2); chk("drain_2", {16'd0, host_rdata}, 32'h30);

`ifdef GLB_PSUM_ACCUM_EN
    // Accumulate with same-address back-to-back forwarding, then wrap
    host_wr(2'd2, 10'd4, 16'h0000);
    psum_wr(10'd4, 16'h0005);
    psum_wr(10'd4, 16'h0007);
    idle(); step();
    host_rd(2'd2, 10'd4); chk("accum_sum", {16'd0, host_rdata}, 32'h000C);
    host_wr(2'd2, 10'd6, 16'h0002);
    psum_wr(10'd6, 16'hFFFF);
    idle(); step();
    host_rd(2'd2, 10'd6); chk("accum_wrap", {16'd0, host_rdata}, 32'h0001);
`endif

    // Counter clear collides with a psum write
    idle(); write_en_glb_psum = 1; w_addr_glb_psum = 10'd20; host_clr_count = 1;
    step();
    chk("clr_collision", {21'd0, psum_wr_count}, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      read_req_glb_iact = 1'($urandom); r_addr_glb_iact = AW'($urandom);
      read_req_glb_wght = 1'($urandom); r_addr_glb_wght = AW'($urandom);
      write_en_glb_psum = ($urandom_range(0, 2) == 0);
      w_addr_glb_psum = AW'($urandom_range(0, 15));
      w_data_glb_psum = DW'($urandom);
      host_sel = 2'($urandom);
      case ($urandom_range(0, 2))
        0: host_we = 1;
        1: host_re = 1;
        default: ;
      endcase
      host_addr = AW'($urandom_range(0, 15));
      host_wdata = DW'($urandom);
      host_clr_count = ($urandom_range(0, 31) == 0);
      step();
    end

    // Counter saturation
    idle(); host_clr_count = 1; step();
    for (int i = 0; i < CMAX + 5; i++) psum_wr(AW'($urandom), DW'($urandom));
    chk("count_saturate", {21'd0, psum_wr_count}, CMAX);

    // Reset in the cycle after a router read and psum write
    idle(); step(); step();
    old9 = m_mem[2][9];
    idle();
    read_req_glb_iact = 1; r_addr_glb_iact = 10'd5;
    write_en_glb_psum = 1; w_addr_glb_psum = 10'd9; w_data_glb_psum = 16'h1234;
    step();
    idle(); reset = 1; #1;
    chk("midrst_r_data_iact", {16'd0, r_data_glb_iact}, 0);
    chk("midrst_host_rvalid", {31'd0, host_rvalid}, 0);
    @(posedge clk); #1;
    reset = 0;
    m_pv = 0; e_iact = '0; e_wght = '0; e_hv = 0; e_hd = '0; m_cnt = 0;
    host_rd(2'd2, 10'd9);
`ifdef GLB_PSUM_ACCUM_EN
    chk("midrst_psum", {16'd0, host_rdata}, {16'd0, old9});
`else
    chk("midrst_psum", {16'd0, host_rdata}, 32'h1234);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
